mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one memory port between the CPU instruction-fetch bus (ibus) and the load/store bus (dbus), for single-ported unified RAM.
- Sits between the CPU core and the memory model in the top-level wrapper.
- Handshake is req/ack. The memory side may take any number of cycles. A timeout counter guards against a hung memory.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the memory port.
- DATA_WIDTH, 32, data width of both requesters and the memory port.
- TIMEOUT, 16, maximum BUSY cycles before an error completion; 0 disables the timeout.

Ports:
- i_clk  in  1  clock. One clock domain; all logic on the rising edge.
- i_rst  in  1  reset. Synchronous, active-high.
- i_ibus_req  in  1  instruction fetch request, level, held until ack.
- i_ibus_addr  in  ADDR_WIDTH  fetch address.
- o_ibus_rdata  out  DATA_WIDTH  fetched word, valid with ack.
- o_ibus_ack  out  1  one-cycle completion pulse.
- o_ibus_err  out  1  timeout flag, valid with ack.
- i_dbus_req  in  1  data request, level, held until ack.
- i_dbus_we  in  1  1 = write, 0 = read.
- i_dbus_addr  in  ADDR_WIDTH  data address.
- i_dbus_wdata  in  DATA_WIDTH  write data.
- o_dbus_rdata  out  DATA_WIDTH  read data, valid with ack.
- o_dbus_ack  out  1  one-cycle completion pulse.
- o_dbus_err  out  1  timeout flag, valid with ack.
- o_mem_req  out  1  memory request, held until i_mem_ack.
- o_mem_we  out  1  write enable to memory.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_wdata  out  DATA_WIDTH  memory write data.
- i_mem_rdata  in  DATA_WIDTH  memory read data, valid with i_mem_ack.
- i_mem_ack  in  1  memory completion; only meaningful while o_mem_req = 1.

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset state is IDLE, owner = IBUS, last_grant = IBUS.
- FSM states:
  - IDLE: if any request is present, latch owner, addr, we and wdata from the winner; o_mem_req <= 1; go to BUSY.
  - BUSY: hold o_mem_req and the latched fields stable. On i_mem_ack: capture i_mem_rdata, pulse the owner's ack, o_mem_req <= 0, go to DONE.
  - DONE: ack is high this cycle, then IDLE. Requesters sample ack here, so a held req is not re-granted.
- Latency:
  - Request seen in IDLE at cycle T gives o_mem_req = 1 at T+1.
  - i_mem_ack at cycle A (A ≥ T+1) gives x_ack = 1 at A+1.
  - Earliest re-arbitration is at A+2.
- Arbitration: fixed priority, dbus over ibus. last_grant is updated on every grant.
- ibus grants always set o_mem_we = 0 and o_mem_wdata = 0.
- Read data: o_x_rdata = captured data, valid only while ack = 1; held otherwise. For writes, rdata is don't-care but deterministic: the captured value.
- The non-owner's ack and err always stay 0.
- Timeout: a counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT-1 with no ack: go to DONE with x_ack = 1, x_err = 1, rdata = 0, o_mem_req <= 0.
  - If i_mem_ack arrives in that same cycle, ack wins (err = 0).
  - The counter saturates and does not wrap. TIMEOUT = 0 disables the counter entirely.
- i_mem_ack outside BUSY is ignored.
- A requester dropping req while in BUSY is a protocol violation. The transaction still completes and the ack is still issued.
- Reset mid-transaction aborts it: o_mem_req = 0 on the next cycle and no ack is issued.

Optional Feature:
- Macro: MEM_BUS_ARBITER_RR_EN.
- Defined: round-robin. When both requesters are present in IDLE, the one that is not last_grant wins. A single requester always wins.
- Undefined: fixed dbus-over-ibus priority. last_grant is still tracked but unused.

Decomposition:
- Shared package (types.sv): typedef enum arb_state_t {IDLE, BUSY, DONE}; typedef enum arb_owner_t {IBUS, DBUS}.
- Sub-module bus_timeout_counter: parameter TIMEOUT; inputs clr, en; output expired. Saturating; expired is tied to 0 when TIMEOUT = 0.

Test Plan:
- Lone ibus read of 0x100, memory acks 3 cycles after o_mem_req with 0xDEADBEEF -> o_ibus_ack for one cycle, rdata = 0xDEADBEEF, err = 0, o_dbus_ack never asserted.
- ibus and dbus write (addr 0x200, wdata 0x12345678) raised in the same cycle -> dbus served first with o_mem_we = 1 and those values, then ibus. With RR_EN and last_grant = DBUS, ibus is served first.
- Memory never acks, TIMEOUT = 16 -> x_ack = 1, x_err = 1, rdata = 0 exactly 16 cycles after o_mem_req rose, then o_mem_req = 0.
- i_mem_ack coincides with the timeout cycle -> err = 0, data returned.
- i_rst asserted while BUSY -> o_mem_req = 0 on the next cycle, no acks. A request after reset is served normally.
- Back-to-back dbus requests with req held continuously -> exactly one ack per transaction, and o_mem_req is low for at least the DONE cycle between them.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus memory arbiter: FSM states, bus owner
// encoding and the timeout counter width helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        IBUS = 1'b0,
        DBUS = 1'b1
    } arb_owner_t;

    // Width of a counter that must reach timeout-1; never narrower than one bit.
    function automatic int unsigned count_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_counter.sv
// Saturating BUSY-cycle counter for the memory arbiter. o_expired is high once
// the count sits at TIMEOUT-1; TIMEOUT = 0 removes the counter altogether.
module bus_timeout_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = count_width(TIMEOUT);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_count;

            // Holds at LAST instead of wrapping, so expired stays asserted.
            always_ff @(posedge i_clk) begin
                if (i_rst || i_clr) begin
                    r_count <= '0;
                end else if (i_en && (r_count != LAST)) begin
                    r_count <= r_count + CW'(1);
                end
            end

            assign o_expired = (r_count == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the instruction-fetch and load/store buses.
// Define MEM_BUS_ARBITER_RR_EN for round-robin; default is dbus-over-ibus priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ibus_req,
    input  logic [ADDR_WIDTH-1:0] i_ibus_addr,
    output logic [DATA_WIDTH-1:0] o_ibus_rdata,
    output logic                  o_ibus_ack,
    output logic                  o_ibus_err,
    input  logic                  i_dbus_req,
    input  logic                  i_dbus_we,
    input  logic [ADDR_WIDTH-1:0] i_dbus_addr,
    input  logic [DATA_WIDTH-1:0] i_dbus_wdata,
    output logic [DATA_WIDTH-1:0] o_dbus_rdata,
    output logic                  o_dbus_ack,
    output logic                  o_dbus_err,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_ack
);

    arb_state_t r_state;
    // r_owner doubles as last_grant: both reset to IBUS and change on every grant.
    arb_owner_t r_owner;

    logic w_any_req;
    logic w_grant_dbus;
    logic w_tmo_clr;
    logic w_tmo_en;
    logic w_expired;
    logic w_done;

    assign w_any_req = i_ibus_req | i_dbus_req;

`ifdef MEM_BUS_ARBITER_RR_EN
    assign w_grant_dbus = i_dbus_req & (~i_ibus_req | (r_owner == IBUS));
`else
    assign w_grant_dbus = i_dbus_req;
`endif

    assign w_tmo_clr = (r_state == IDLE) & w_any_req;
    assign w_tmo_en  = (r_state == BUSY) & ~i_mem_ack;
    // A memory ack in the expiry cycle still completes the access without error.
    assign w_done    = i_mem_ack | w_expired;

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_tmo_clr),
        .i_en      (w_tmo_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_owner      <= IBUS;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_ibus_rdata <= '0;
            o_ibus_ack   <= 1'b0;
            o_ibus_err   <= 1'b0;
            o_dbus_rdata <= '0;
            o_dbus_ack   <= 1'b0;
            o_dbus_err   <= 1'b0;
        end else begin
            // NOTE: acks and errs default low every cycle, so the single
            // assignment in BUSY yields exactly one DONE-cycle pulse.
            o_ibus_ack <= 1'b0;
            o_ibus_err <= 1'b0;
            o_dbus_ack <= 1'b0;
            o_dbus_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        o_mem_req <= 1'b1;
                        r_state   <= BUSY;
                        if (w_grant_dbus) begin
                            r_owner     <= DBUS;
                            o_mem_we    <= i_dbus_we;
                            o_mem_addr  <= i_dbus_addr;
                            o_mem_wdata <= i_dbus_wdata;
                        end else begin
                            r_owner     <= IBUS;
                            o_mem_we    <= 1'b0;
                            o_mem_addr  <= i_ibus_addr;
                            o_mem_wdata <= '0;
                        end
                    end
                end

                BUSY: begin
                    if (w_done) begin
                        o_mem_req <= 1'b0;
                        r_state   <= DONE;
                        if (r_owner == DBUS) begin
                            o_dbus_ack   <= 1'b1;
                            o_dbus_err   <= ~i_mem_ack;
                            o_dbus_rdata <= i_mem_ack ? i_mem_rdata : '0;
                        end else begin
                            o_ibus_ack   <= 1'b1;
                            o_ibus_err   <= ~i_mem_ack;
                            o_ibus_rdata <= i_mem_ack ? i_mem_rdata : '0;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table plus hand-written
// reset, stray-ack and back-to-back sequences, checked through a scoreboard.
module tb_mem_bus_arbiter;

    localparam int TO = 16;

    logic        i_clk;
    logic        i_rst;
    logic        i_ibus_req;
    logic [31:0] i_ibus_addr;
    logic [31:0] o_ibus_rdata;
    logic        o_ibus_ack;
    logic        o_ibus_err;
    logic        i_dbus_req;
    logic        i_dbus_we;
    logic [31:0] i_dbus_addr;
    logic [31:0] i_dbus_wdata;
    logic [31:0] o_dbus_rdata;
    logic        o_dbus_ack;
    logic        o_dbus_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;

    mem_bus_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ibus_req   (i_ibus_req),
        .i_ibus_addr  (i_ibus_addr),
        .o_ibus_rdata (o_ibus_rdata),
        .o_ibus_ack   (o_ibus_ack),
        .o_ibus_err   (o_ibus_err),
        .i_dbus_req   (i_dbus_req),
        .i_dbus_we    (i_dbus_we),
        .i_dbus_addr  (i_dbus_addr),
        .i_dbus_wdata (i_dbus_wdata),
        .o_dbus_rdata (o_dbus_rdata),
        .o_dbus_ack   (o_dbus_ack),
        .o_dbus_err   (o_dbus_err),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_ack    (i_mem_ack)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One memory transaction: grant fields, memory response and expected completion.
    typedef struct {
        bit          is_dbus;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        bit          hang;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        bit          ireq;
        logic [31:0] iaddr;
        int          idelay;
        bit          ihang;
        logic [31:0] idata;
        bit          dreq;
        bit          dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        int          ddelay;
        bit          dhang;
        logic [31:0] ddata;
    } vec_t;

    txn_t exp_q[$];
    txn_t resp_q[$];
    txn_t resp_cur;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int rise_cyc  = 0;
    int resp_cnt  = 0;
    int ireq_left = 0;
    int dreq_left = 0;
    bit prev_req    = 1'b0;
    bit prev_ack    = 1'b0;
    bit resp_active = 1'b0;
    bit stray_ack   = 1'b0;
    bit last_dbus   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        txn_t        t;
        logic [31:0] exp_rd;
        if (o_mem_req === 1'b1 && !prev_req) begin
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious mem_req", 1, 0);
            end else begin
                t = exp_q[0];
                check("mem_we", o_mem_we, t.we);
                check("mem_addr", o_mem_addr, t.addr);
                check("mem_wdata", o_mem_wdata, t.wdata);
            end
        end
        if (o_ibus_ack === 1'b1 || o_dbus_ack === 1'b1) begin
            check("ack pulse width", prev_ack, 0);
            if (exp_q.size() == 0) begin
                check("spurious ack", 1, 0);
            end else begin
                t = exp_q.pop_front();
                exp_rd = t.hang ? 32'h0 : t.data;
                check("ack/err vector", {o_ibus_ack, o_ibus_err, o_dbus_ack, o_dbus_err},
                      {!t.is_dbus, t.hang && !t.is_dbus, t.is_dbus, t.hang && t.is_dbus});
                check("rdata", t.is_dbus ? o_dbus_rdata : o_ibus_rdata, exp_rd);
                check("ack latency", cyc - rise_cyc, t.hang ? TO : t.delay + 1);
                check("mem_req low at ack", o_mem_req, 0);
                if (t.is_dbus) begin
                    if (dreq_left > 0) dreq_left--;
                    if (dreq_left == 0) i_dbus_req = 1'b0;
                end else begin
                    if (ireq_left > 0) ireq_left--;
                    if (ireq_left == 0) i_ibus_req = 1'b0;
                end
            end
        end
        prev_req = (o_mem_req === 1'b1);
        prev_ack = (o_ibus_ack === 1'b1) || (o_dbus_ack === 1'b1);
    endtask

    // Memory model: acks 'delay' cycles after o_mem_req rose, never when hung.
    task automatic respond();
        if (o_mem_req !== 1'b1) begin
            resp_active = 1'b0;
            i_mem_ack   = stray_ack;
            i_mem_rdata = $urandom();
        end else begin
            if (!resp_active) begin
                resp_active = 1'b1;
                resp_cnt    = 0;
                if (resp_q.size() > 0) resp_cur = resp_q.pop_front();
                else resp_cur.hang = 1'b1;
            end
            if (!resp_cur.hang && resp_cnt == resp_cur.delay) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = resp_cur.data;
            end else begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = $urandom();
            end
            resp_cnt++;
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        cyc++;
        monitor();
        respond();
    endtask

    task automatic push_txn(input txn_t t);
        exp_q.push_back(t);
        resp_q.push_back(t);
        last_dbus = t.is_dbus;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || i_ibus_req || i_dbus_req) && n < 300) begin
            tick();
            n++;
        end
        check({name, " completed in budget"}, n < 300, 1);
        if (n >= 300) begin
            exp_q.delete();
            resp_q.delete();
            i_ibus_req = 1'b0;
            i_dbus_req = 1'b0;
            ireq_left  = 0;
            dreq_left  = 0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        txn_t ti;
        txn_t td;
        bit   dfirst;
        ti = '{is_dbus: 1'b0, we: 1'b0, addr: v.iaddr, wdata: 32'h0,
               delay: v.idelay, hang: v.ihang, data: v.idata};
        td = '{is_dbus: 1'b1, we: v.dwe, addr: v.daddr, wdata: v.dwdata,
               delay: v.ddelay, hang: v.dhang, data: v.ddata};
`ifdef MEM_BUS_ARBITER_RR_EN
        dfirst = !last_dbus;
`else
        dfirst = 1'b1;
`endif
        if (v.ireq && v.dreq) begin
            if (dfirst) begin push_txn(td); push_txn(ti); end
            else        begin push_txn(ti); push_txn(td); end
        end else if (v.ireq) begin
            push_txn(ti);
        end else if (v.dreq) begin
            push_txn(td);
        end
        i_ibus_addr  = v.iaddr;
        i_dbus_we    = v.dwe;
        i_dbus_addr  = v.daddr;
        i_dbus_wdata = v.dwdata;
        i_ibus_req   = v.ireq;
        i_dbus_req   = v.dreq;
        ireq_left    = v.ireq ? 1 : 0;
        dreq_left    = v.dreq ? 1 : 0;
        wait_done($sformatf("vec%0d", idx));
        repeat (2) tick();
    endtask

    vec_t vecs[8];

    initial begin
        txn_t t;
        int   n;

        // ireq, iaddr, idelay, ihang, idata, dreq, dwe, daddr, dwdata, ddelay, dhang, ddata
        vecs[0] = '{1, 32'h100, 3, 0, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0,        0,  0, 32'h0};
        vecs[1] = '{1, 32'h104, 0, 0, 32'h11112222, 1, 1, 32'h200, 32'h12345678, 2,  0, 32'hCAFE0001};
        vecs[2] = '{0, 32'h0,   0, 0, 32'h0,        1, 0, 32'h300, 32'h0,        1,  0, 32'h0BADF00D};
        vecs[3] = '{1, 32'h108, 4, 0, 32'h01020304, 1, 0, 32'h304, 32'h0,        0,  0, 32'hA5A5A5A5};
        vecs[4] = '{1, 32'h10C, 0, 1, 32'h99999999, 0, 0, 32'h0,   32'h0,        0,  0, 32'h0};
        vecs[5] = '{0, 32'h0,   0, 0, 32'h0,        1, 0, 32'h400, 32'h0,        15, 0, 32'h55AA55AA};
        vecs[6] = '{0, 32'h0,   0, 0, 32'h0,        1, 1, 32'h404, 32'hFEEDFACE, 0,  1, 32'h77777777};
        vecs[7] = '{1, 32'h110, 7, 0, 32'h77777777, 1, 1, 32'h408, 32'h89ABCDEF, 0,  0, 32'h13579BDF};

        i_rst        = 1'b1;
        i_ibus_req   = 1'b0;
        i_ibus_addr  = '0;
        i_dbus_req   = 1'b0;
        i_dbus_we    = 1'b0;
        i_dbus_addr  = '0;
        i_dbus_wdata = '0;
        i_mem_ack    = 1'b0;
        i_mem_rdata  = '0;
        repeat (3) tick();

        check("reset mem_req",    o_mem_req, 0);
        check("reset mem_we",     o_mem_we, 0);
        check("reset mem_addr",   o_mem_addr, 0);
        check("reset mem_wdata",  o_mem_wdata, 0);
        check("reset ibus_ack",   o_ibus_ack, 0);
        check("reset ibus_err",   o_ibus_err, 0);
        check("reset ibus_rdata", o_ibus_rdata, 0);
        check("reset dbus_ack",   o_dbus_ack, 0);
        check("reset dbus_err",   o_dbus_err, 0);
        check("reset dbus_rdata", o_dbus_rdata, 0);

        i_rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Memory acks while idle must not start or complete anything.
        stray_ack = 1'b1;
        repeat (4) begin
            tick();
            check("stray ack ignored", {o_mem_req, o_ibus_ack, o_dbus_ack}, 3'b000);
        end
        stray_ack = 1'b0;
        repeat (2) tick();

        // Reset while BUSY aborts the access with no ack.
        t = '{is_dbus: 1'b0, we: 1'b0, addr: 32'h500, wdata: 32'h0,
              delay: 0, hang: 1'b1, data: 32'h0};
        push_txn(t);
        i_ibus_addr = 32'h500;
        i_ibus_req  = 1'b1;
        ireq_left   = 1;
        n = 0;
        while (o_mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("abort: mem_req rose", o_mem_req, 1);
        repeat (3) tick();
        i_rst      = 1'b1;
        i_ibus_req = 1'b0;
        ireq_left  = 0;
        exp_q.delete();
        resp_q.delete();
        last_dbus  = 1'b0;
        tick();
        check("abort: mem_req dropped", o_mem_req, 0);
        check("abort: no acks", {o_ibus_ack, o_dbus_ack}, 2'b00);
        tick();
        i_rst = 1'b0;
        repeat (TO + 4) begin
            tick();
            check("abort: stays quiet", {o_mem_req, o_ibus_ack, o_dbus_ack}, 3'b000);
        end
        run_vec('{1, 32'h600, 2, 0, 32'h60606060, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0}, 100);

        // Back-to-back dbus reads with the request held across all three.
        for (int k = 0; k < 3; k++) begin
            t = '{is_dbus: 1'b1, we: 1'b0, addr: 32'h700, wdata: 32'h0,
                  delay: (k == 1) ? 2 : k, hang: 1'b0, data: 32'hB0B0_0000 + 32'(k)};
            push_txn(t);
        end
        i_dbus_we    = 1'b0;
        i_dbus_addr  = 32'h700;
        i_dbus_wdata = 32'h0;
        i_dbus_req   = 1'b1;
        dreq_left    = 3;
        wait_done("back-to-back");
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
